// File: rtl/input_pkg.sv
// Shared constants for the front-end command arbiter: source tags, slot widths
// and the round-robin pointer step.
package input_pkg;

   localparam int NUM_SRC = 3;
   localparam int BTN_W   = 5;
   localparam int SW_W    = 3;
   localparam int CMD_W   = 8;

   localparam logic [1:0] SRC_BTN  = 2'd0;
   localparam logic [1:0] SRC_SW   = 2'd1;
   localparam logic [1:0] SRC_UART = 2'd2;

   // Pointer value that follows a grant to slot idx (idx+1 mod 3).
   function automatic logic [1:0] next_ptr(input logic [1:0] idx);
      return (idx == SRC_UART) ? SRC_BTN : idx + 2'd1;
   endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Combinational three-way round-robin pick: first pending slot found at ptr,
// ptr+1, ptr+2 (mod 3) wins.
module rr_arbiter3
   import input_pkg::*;
(
   input  logic [NUM_SRC-1:0] pending,
   input  logic [1:0]         ptr,
   output logic [NUM_SRC-1:0] grant,
   output logic [1:0]         idx,
   output logic               any
);

   int k;

   // NOTE: every output gets a default before the search so no path leaves a
   // value unassigned, which would otherwise infer a latch.
   always_comb begin
      grant = '0;
      idx   = SRC_BTN;
      any   = 1'b0;
      k     = 0;
      for (int i = 0; i < NUM_SRC; i++) begin
         k = (int'(ptr) + i) % NUM_SRC;
         if (!any && pending[k]) begin
            any      = 1'b1;
            grant[k] = 1'b1;
            idx      = 2'(k);
         end
      end
   end

endmodule

// File: rtl/input_cmd_arbiter.sv
// Merges button, switch and UART events into one valid/ready command stream
// through one-deep pending slots, a round-robin pick and an output register.
module input_cmd_arbiter
   import input_pkg::*;
#(
   parameter int STALL_CYCLES = 1_000_000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [BTN_W-1:0] i_btn_pulse,
   input  logic [SW_W-1:0]  i_sw_level,
   input  logic [CMD_W-1:0] i_uart_mode,
   input  logic             i_uart_valid,
   output logic [CMD_W-1:0] o_cmd_data,
   output logic [1:0]       o_cmd_src,
   output logic             o_cmd_valid,
   input  logic             i_cmd_ready,
   output logic [7:0]       o_drop_cnt,
   output logic             o_stall
);

   localparam int               CNT_W     = $clog2(STALL_CYCLES + 1);
   localparam logic [CNT_W-1:0] STALL_MAX = CNT_W'(STALL_CYCLES);

   logic [BTN_W-1:0]   btn_slot;
   logic [SW_W-1:0]    sw_slot;
   logic [SW_W-1:0]    sw_last;
   logic [CMD_W-1:0]   uart_slot;
   logic [NUM_SRC-1:0] pending;
   logic [NUM_SRC-1:0] grant;
   logic [NUM_SRC-1:0] take;
   logic [1:0]         ptr;
   logic [1:0]         win_idx;
   logic               win_any;
   logic [CMD_W-1:0]   win_data;
   logic               sw_armed;
   logic               load;
   logic               handshake;
   logic               btn_event;
   logic               sw_event;
   logic               btn_drop;
   logic               uart_drop;
   logic [8:0]         drop_sum;
   logic [CNT_W-1:0]   stall_cnt;

   rr_arbiter3 u_arb (
      .pending (pending),
      .ptr     (ptr),
      .grant   (grant),
      .idx     (win_idx),
      .any     (win_any)
   );

   assign handshake = o_cmd_valid & i_cmd_ready;
   assign load      = (!o_cmd_valid | i_cmd_ready) & win_any;
   assign take      = load ? grant : '0;
   assign btn_event = |i_btn_pulse;
   assign sw_event  = sw_armed & (i_sw_level != sw_last);

   // A slot that is granted this cycle is being emptied, so new content never
   // counts as an overwrite.
   assign btn_drop  = btn_event & pending[SRC_BTN] & !take[SRC_BTN]
                    & (|(btn_slot & i_btn_pulse));
   assign uart_drop = i_uart_valid & pending[SRC_UART] & !take[SRC_UART];
   assign drop_sum  = {1'b0, o_drop_cnt} + 9'(btn_drop) + 9'(uart_drop);

   always_comb begin
      case (win_idx)
         SRC_SW:   win_data = {{(CMD_W-SW_W){1'b0}}, sw_slot};
         SRC_UART: win_data = uart_slot;
         default:  win_data = {{(CMD_W-BTN_W){1'b0}}, btn_slot};
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         btn_slot  <= '0;
         sw_slot   <= '0;
         sw_last   <= '0;
         uart_slot <= '0;
         pending   <= '0;
         sw_armed  <= 1'b0;
      end else begin
         if (take[SRC_BTN]) begin
            btn_slot         <= i_btn_pulse;
            pending[SRC_BTN] <= btn_event;
         end else if (btn_event) begin
            btn_slot         <= btn_slot | i_btn_pulse;
            pending[SRC_BTN] <= 1'b1;
         end

         if (!sw_armed) begin
            sw_armed <= 1'b1;
            sw_last  <= i_sw_level;
         end else if (sw_event) begin
            sw_last  <= i_sw_level;
         end
         if (sw_event) begin
            sw_slot         <= i_sw_level;
            pending[SRC_SW] <= 1'b1;
         end else if (take[SRC_SW]) begin
            pending[SRC_SW] <= 1'b0;
         end

         if (i_uart_valid) begin
            uart_slot         <= i_uart_mode;
            pending[SRC_UART] <= 1'b1;
         end else if (take[SRC_UART]) begin
            pending[SRC_UART] <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         o_cmd_data  <= '0;
         o_cmd_src   <= SRC_BTN;
         o_cmd_valid <= 1'b0;
         ptr         <= SRC_UART;
      end else if (load) begin
         o_cmd_data  <= win_data;
         o_cmd_src   <= win_idx;
         o_cmd_valid <= 1'b1;
         ptr         <= next_ptr(win_idx);
      end else if (handshake) begin
         o_cmd_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         o_drop_cnt <= '0;
      end else begin
         o_drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
      end
   end

   // Watchdog: counts stalled cycles; o_stall rises on the edge the count
   // reaches STALL_CYCLES and both clear on the next handshake.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt <= '0;
         o_stall   <= 1'b0;
      end else if (handshake) begin
         stall_cnt <= '0;
         o_stall   <= 1'b0;
      end else if (o_cmd_valid) begin
         if (stall_cnt != STALL_MAX) begin
            stall_cnt <= stall_cnt + 1'b1;
         end
         if (stall_cnt >= STALL_MAX - 1'b1) begin
            o_stall <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_input_cmd_arbiter.sv
// Scoreboard bench: stimulus pushes expected {src,data} words, a negedge
// monitor pops and compares them on every handshake.
module tb_input_cmd_arbiter;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [4:0] i_btn_pulse = '0;
   logic [2:0] i_sw_level = '0;
   logic [7:0] i_uart_mode = '0;
   logic       i_uart_valid = 1'b0;
   logic       i_cmd_ready = 1'b0;
   logic [7:0] o_cmd_data;
   logic [1:0] o_cmd_src;
   logic       o_cmd_valid;
   logic [7:0] o_drop_cnt;
   logic       o_stall;

   int         total = 0;
   int         bad = 0;
   logic [9:0] exp_q[$];
   logic [9:0] mon_exp;

   input_cmd_arbiter #(.STALL_CYCLES(10)) dut (
      .clk          (clk),
      .reset        (reset),
      .i_btn_pulse  (i_btn_pulse),
      .i_sw_level   (i_sw_level),
      .i_uart_mode  (i_uart_mode),
      .i_uart_valid (i_uart_valid),
      .o_cmd_data   (o_cmd_data),
      .o_cmd_src    (o_cmd_src),
      .o_cmd_valid  (o_cmd_valid),
      .i_cmd_ready  (i_cmd_ready),
      .o_drop_cnt   (o_drop_cnt),
      .o_stall      (o_stall)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic idle();
      i_btn_pulse  = '0;
      i_uart_valid = 1'b0;
      i_uart_mode  = '0;
   endtask

   task automatic push(input logic [1:0] src, input logic [7:0] data);
      exp_q.push_back({src, data});
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_valid"}, 32'(o_cmd_valid), 0);
      check({tag, "_data"},  32'(o_cmd_data), 0);
      check({tag, "_src"},   32'(o_cmd_src), 0);
      check({tag, "_drop"},  32'(o_drop_cnt), 0);
      check({tag, "_stall"}, 32'(o_stall), 0);
   endtask

   // Monitor: a handshake is visible at the negedge before the accepting edge.
   always @(negedge clk) begin
      if (reset && o_cmd_valid && i_cmd_ready) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_cmd: got src=%0d data=%0h expected no command",
                     o_cmd_src, o_cmd_data);
         end else begin
            mon_exp = exp_q.pop_front();
            check("cmd", {22'd0, o_cmd_src, o_cmd_data}, {22'd0, mon_exp});
         end
      end
   end

   initial begin
      // Reset and first cycle: switch level held across release raises nothing.
      reset       = 1'b0;
      i_sw_level  = 3'b101;
      i_cmd_ready = 1'b1;
      idle();
      tick(3);
      check_zero_outputs("rst");
      reset = 1'b1;
      tick(6);
      check_zero_outputs("post_rst");

      // Three simultaneous sources: UART first (ptr=2), then BTN, then SW.
      i_btn_pulse  = 5'b00100;
      i_uart_valid = 1'b1;
      i_uart_mode  = 8'h41;
      i_sw_level   = 3'b010;
      push(2'd2, 8'h41);
      push(2'd0, 8'h04);
      push(2'd1, 8'h02);
      tick();
      idle();
      tick(6);
      check("simul_drain", 32'(exp_q.size()), 0);

      // Stalled consumer with UART overwrite.
      i_cmd_ready  = 1'b0;
      i_uart_valid = 1'b1;
      i_uart_mode  = 8'h31;
      push(2'd2, 8'h31);
      tick();
      idle();
      tick();
      check("uart_hold_valid", 32'(o_cmd_valid), 1);
      i_uart_valid = 1'b1;
      i_uart_mode  = 8'h32;
      tick();
      i_uart_mode  = 8'h33;
      tick();
      idle();
      check("uart_drop", 32'(o_drop_cnt), 1);
      check("uart_hold_data", 32'(o_cmd_data), 32'h31);
      push(2'd2, 8'h33);
      i_cmd_ready = 1'b1;
      tick(3);
      i_cmd_ready = 1'b0;
      check("uart_drain", 32'(exp_q.size()), 0);

      // BTN merge and collision behind a held UART command.
      i_uart_valid = 1'b1;
      i_uart_mode  = 8'h50;
      push(2'd2, 8'h50);
      tick();
      idle();
      tick();
      i_btn_pulse = 5'b00001;
      tick();
      i_btn_pulse = 5'b01000;
      tick();
      i_btn_pulse = 5'b00001;
      tick();
      i_btn_pulse = 5'b00000;
      check("btn_drop", 32'(o_drop_cnt), 2);
      push(2'd0, 8'h09);
      i_cmd_ready = 1'b1;
      tick(3);
      i_cmd_ready = 1'b0;
      check("btn_drain", 32'(exp_q.size()), 0);

      // Grant and a new pulse in the same cycle: no drop, only new bits kept.
      i_cmd_ready = 1'b1;
      i_btn_pulse = 5'b00001;
      push(2'd0, 8'h01);
      push(2'd0, 8'h10);
      tick();
      i_btn_pulse = 5'b10000;
      tick();
      i_btn_pulse = 5'b00000;
      tick(3);
      check("same_cycle_drop", 32'(o_drop_cnt), 2);
      check("same_cycle_drain", 32'(exp_q.size()), 0);

      // Stall watchdog at STALL_CYCLES = 10.
      i_cmd_ready  = 1'b0;
      i_uart_valid = 1'b1;
      i_uart_mode  = 8'h77;
      push(2'd2, 8'h77);
      tick();
      idle();
      tick();
      check("stall_valid", 32'(o_cmd_valid), 1);
      tick(9);
      check("stall_early", 32'(o_stall), 0);
      tick();
      check("stall_set", 32'(o_stall), 1);
      i_cmd_ready = 1'b1;
      tick();
      i_cmd_ready = 1'b0;
      check("stall_clear", 32'(o_stall), 0);
      check("stall_consumed", 32'(o_cmd_valid), 0);

      // Reset mid-stall discards the held command and a pending slot.
      i_uart_valid = 1'b1;
      i_uart_mode  = 8'h78;
      tick();
      idle();
      tick();
      i_uart_valid = 1'b1;
      i_uart_mode  = 8'h79;
      tick();
      idle();
      tick(11);
      check("stall_again", 32'(o_stall), 1);
      reset = 1'b0;
      #1;
      check_zero_outputs("mid_rst");
      tick(2);
      reset       = 1'b1;
      i_cmd_ready = 1'b1;
      tick(6);
      check("mid_rst_no_cmd", 32'(o_cmd_valid), 0);

      for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
      check("final_drain", 32'(exp_q.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/input_cmd_arbiter.md
# input_cmd_arbiter

Shares the single downstream command path among three event sources of the board front end: debounced button pulses, switch level changes, and decoded UART mode bytes. Each source owns a one-deep pending slot; a round-robin arbiter grants one slot at a time into an output register with a valid/ready handshake. The block sits between the input synchronisers/ASCII decoder and the mode/control FSM, replacing plain OR-merging so that no event is silently combined or lost without being counted.

## Interface
- `STALL_CYCLES`, default 1_000_000: cycles `o_cmd_valid` may stay high without `i_cmd_ready` before `o_stall` asserts.
- `clk` input 1: single clock; all logic is rising-edge.
- `reset` input 1: asynchronous, active-low (0 = reset); deassertion is synchronous to `clk` upstream.
- `i_btn_pulse` input 5: one-cycle button pulses, already debounced and synchronised.
- `i_sw_level` input 3: synchronised switch levels.
- `i_uart_mode` input 8: decoded UART mode byte.
- `i_uart_valid` input 1: one-cycle strobe; `i_uart_mode` is valid in the same cycle.
- `o_cmd_data` output 8: command payload.
- `o_cmd_src` output 2: source tag: 0 = BTN, 1 = SW, 2 = UART. Value 3 is never driven.
- `o_cmd_valid` output 1: command available.
- `i_cmd_ready` input 1: consumer accepts when `o_cmd_valid & i_cmd_ready`.
- `o_drop_cnt` output 8: saturating count of overwritten BTN and UART pending events.
- `o_stall` output 1: consumer stalled beyond `STALL_CYCLES`.

## Operation
- **BTN slot.** Any `i_btn_pulse` bit set: slot bits |= pulse bits, and the slot is marked pending. A bit already set in a pending slot is a drop; `o_drop_cnt` increments by 1 per cycle, regardless of how many bits collided. Payload is `{3'b000, slot[4:0]}`.
- **SW slot.**
  - The first cycle after reset release loads `sw_last` with `i_sw_level` and raises no event.
  - After that, `i_sw_level != sw_last` updates `sw_last`, loads the slot with the new level and marks it pending.
  - Overwriting a pending SW slot is coalescing, not a drop.
  - Payload is `{5'b0, level}`.
- **UART slot.** `i_uart_valid` loads the slot with `i_uart_mode` and marks it pending. Overwriting a pending UART slot increments `o_drop_cnt`. Payload is the byte unchanged.
- **Output load.** The output register loads when it is empty or is handshaking in the same cycle (`!o_cmd_valid | i_cmd_ready`) and at least one slot is pending.
- **Round-robin.**
  - The winner is the first pending slot in the order starting at `ptr`, then `ptr+1`, then `ptr+2` (mod 3).
  - After a grant to slot k, `ptr` becomes k+1 mod 3.
  - Reset `ptr` = 2, so UART wins first.
- **Grant and new event in the same cycle.**
  - The granted slot clears.
  - The new event then sets the slot again with only the new content. For BTN, only the new bits are kept.
  - No drop is counted.
- **`o_drop_cnt`** saturates at 255 and clears only on reset.
- **`o_stall`.**
  - A stall counter runs while `o_cmd_valid & !i_cmd_ready`.
  - `o_stall` sets when the counter reaches `STALL_CYCLES`.
  - The counter and `o_stall` both clear on a handshake.
- **Reset values.** `o_cmd_data` = 0, `o_cmd_src` = 0, `o_cmd_valid` = 0, `o_drop_cnt` = 0, `o_stall` = 0. All slots are empty, `sw_last` = 0, `ptr` = 2.
- **Reset mid-operation.** Every pending slot and any held command are discarded immediately.

## Timing
- **Latency.** An event sampled at edge n is pending after edge n. `o_cmd_valid` is high after edge n+1 if the output is free. This 2-cycle latency is fixed; no bypass.
- **Throughput.** One command per cycle while `i_cmd_ready` stays high.
- **Handshake rules.**
  - `o_cmd_data` and `o_cmd_src` hold stable while `o_cmd_valid & !i_cmd_ready`.
  - `o_cmd_valid` never drops without a handshake, except on reset.
- **`o_stall` timing.** `o_stall` rises on the edge where the stall counter equals `STALL_CYCLES`. It falls on the edge after a handshake.
- **Stall counter width.** clog2(`STALL_CYCLES`+1).

## Structure
- **Package `input_pkg`:**
  - Source tag constants: `SRC_BTN` = 0, `SRC_SW` = 1, `SRC_UART` = 2.
  - Source count 3.
  - Widths: `BTN_W` = 5, `SW_W` = 3, `CMD_W` = 8.
- **Sub-module `rr_arbiter3`.**
  - Inputs: 3-bit pending, 2-bit pointer.
  - Outputs: one-hot grant, 2-bit index, any-grant.
  - Purely combinational.
- **Top-level contents:** slot registers, edge detect, output register, counters.

## Test plan
- **Reset/first cycle.** Hold `i_sw_level` = 3'b101 through reset release → no SW command; all outputs 0.
- **Simultaneous sources.** Ready held high. In one cycle: BTN pulse 5'b00100, UART 8'h41 valid, SW changes to 3'b010. Required outputs on three consecutive cycles, in order:
  - src 2, data 8'h41
  - src 0, data 8'h04
  - src 1, data 8'h02
- **Stalled consumer, drop counting.** Ready low. Fill the output with UART 8'h31. Then send UART 8'h32 and, while it is still pending, UART 8'h33 → `o_drop_cnt` = 1. Raise ready → outputs 8'h31, then 8'h33.
- **BTN merge and collision.** Ready low. Pulse bit0, then bit3, then bit0 again → `o_drop_cnt` +1. After the held command is consumed, the BTN payload is 8'h09.
- **Grant and new event same cycle.** Pending BTN 5'b00001 is granted in the same cycle as a new pulse 5'b10000 → current command is 8'h01, next is 8'h10, and `o_drop_cnt` is unchanged.
- **Stall watchdog.** `STALL_CYCLES` = 10, ready low after `o_cmd_valid` → `o_stall` high exactly 10 cycles later. One ready pulse → `o_stall` low the next cycle. Also assert reset mid-stall → all outputs 0.
